// File: rtl/prio_enc_pkg.sv
// Shared types and constants for the priority-encoder arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package prio_enc_pkg;

  // Arbiter FSM: IDLE holds no winner, HOLD presents a registered winner.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Priority mode encodings carried on the mode input.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Round-robin pointer after granting index 'grant' out of 'n' lines:
  // the next search starts just below the last winner, wrapping to the top.
  function automatic int rr_next_ptr(input int grant, input int n);
    return (grant == 0) ? n - 1 : grant - 1;
  endfunction

endpackage

// File: rtl/prio_rot_search.sv
// Combinational rotating priority search: finds the first set req bit scanning downward from a start index.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when the result is consumed.
module prio_rot_search
  import prio_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic         found,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  // Pick the set bit closest to the start index in downward, wrapping order.
  // Fixed mode starts at N-1, so wrap never matters there; round-robin
  // starts at ptr. Distance (start - i) mod N gives the scan rank of bit i,
  // and the smallest rank among set bits wins.
  always_comb begin
    int start;
    int best;
    int best_d;
    int d;
    start  = (mode == MODE_RR) ? int'(ptr) : N - 1;
    // Out-of-range pointer can only appear for non-power-of-two N if state
    // were corrupted; clamp so the output stays well defined.
    if (start > N - 1) begin
      start = N - 1;
    end
    best   = 0;
    best_d = N;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      d = (start >= i) ? start - i : start + N - i;
      if (req[i] && (d < best_d)) begin
        best   = i;
        best_d = d;
        found  = 1'b1;
      end
    end
    idx = W'(best);
    for (int i = 0; i < N; i++) begin
      onehot[i] = found && (best == i);
    end
  end

endmodule

// File: rtl/prio_enc_arb.sv
// Registered priority-encoder arbiter with fixed (MSB-first) or round-robin ordering.
// Latency: 1 cycle from req to out_valid; back-to-back grants on consecutive accepts.
// Backpressure: winner held stable while out_valid && !out_ready; searches run only in IDLE or on accept.
module prio_enc_arb
  import prio_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         none
);

  localparam logic [W-1:0] PTR_RST = W'(N - 1);

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   ptr;
  logic [W-1:0]   ptr_nxt;
  logic           accept;

  logic           s_found;
  logic [W-1:0]   s_idx;
  logic [N-1:0]   s_onehot;

  logic           valid_nxt;
  logic [W-1:0]   idx_nxt;
  logic [N-1:0]   onehot_nxt;
  logic           none_nxt;

  // The consumer takes the presented winner this cycle.
  assign accept = (state == ST_HOLD) && out_valid && out_ready;

  // Advance the round-robin pointer past an accepted winner; fixed mode
  // and stalled cycles leave it alone.
  always_comb begin
    ptr_nxt = ptr;
    if (accept && (mode == MODE_RR)) begin
      ptr_nxt = W'(rr_next_ptr(int'(out_idx), N));
    end
  end

  // The search sees the already-advanced pointer so an accept can load the
  // next winner in the same edge without a bubble.
  prio_rot_search #(
    .N (N)
  ) u_search (
    .req    (req),
    .ptr    (ptr_nxt),
    .mode   (mode),
    .found  (s_found),
    .idx    (s_idx),
    .onehot (s_onehot)
  );

  // Next-state and output decode: search on IDLE cycles and accept cycles,
  // otherwise hold the presented winner untouched.
  always_comb begin
    state_nxt  = state;
    valid_nxt  = out_valid;
    idx_nxt    = out_idx;
    onehot_nxt = out_onehot;
    none_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_found) begin
          state_nxt  = ST_HOLD;
          valid_nxt  = 1'b1;
          idx_nxt    = s_idx;
          onehot_nxt = s_onehot;
        end else begin
          valid_nxt  = 1'b0;
          idx_nxt    = '0;
          onehot_nxt = '0;
          none_nxt   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          if (s_found) begin
            valid_nxt  = 1'b1;
            idx_nxt    = s_idx;
            onehot_nxt = s_onehot;
          end else begin
            state_nxt  = ST_IDLE;
            valid_nxt  = 1'b0;
            idx_nxt    = '0;
            onehot_nxt = '0;
            none_nxt   = 1'b1;
          end
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        valid_nxt  = 1'b0;
        idx_nxt    = '0;
        onehot_nxt = '0;
      end
    endcase
  end

  // State and output registers; reset discards any held winner and
  // restarts round-robin at the top so it matches fixed order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      none       <= 1'b0;
      ptr        <= PTR_RST;
    end else begin
      state      <= state_nxt;
      out_valid  <= valid_nxt;
      out_idx    <= idx_nxt;
      out_onehot <= onehot_nxt;
      none       <= none_nxt;
      ptr        <= ptr_nxt;
    end
  end

endmodule
